uart_rx_engine: RTL
===================

Name: uart_rx_engine

Overview:
Receive half of the UART. Oversamples the serial line with the system clock, detects and validates the start bit, and samples each bit at its centre. Deserializes LSB-first frames into a right-shifting 10-bit register and presents the byte with a ready flag and error flags to the host-side register interface. It is the counterpart of the transmit shift path and uses the same frame format: start, 7/8 data bits, optional parity, one stop bit.

Parameters:
CLKS_PER_BIT, 5208, clock cycles per bit time (50 MHz / 9600 baud); must be >= 4.
CNT_W, $clog2(CLKS_PER_BIT), width of the bit-time counter.

Ports:
clk  input  1  system clock, all state on posedge.
reset  input  1  asynchronous, active-low reset (asserted when 0).
rx  input  1  serial line, asynchronous to clk, idles high.
eight  input  1  1 = 8 data bits, 0 = 7 data bits.
pen  input  1  1 = parity bit present.
ohel  input  1  parity sense: 1 = odd, 0 = even.
rd_clr  input  1  single-cycle strobe from host read; clears rx_rdy and ovf.
rx_data  output  8  received character; bit 7 = 0 in 7-bit mode.
rx_rdy  output  1  character available, sticky until rd_clr.
perr  output  1  parity error for the character in rx_data.
ferr  output  1  framing error (stop bit sampled 0).
ovf  output  1  overrun: new character loaded while rx_rdy was still set.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; synchronizer and shift register all 1s; counters 0; rx_data=0; rx_rdy, perr, ferr, ovf, busy = 0.
- rx passes through a 2-flop synchronizer (reset value 1) to give rx_s. All decisions use rx_s.
- Bit timer: loaded with N-1, decrements each clock, and expires at 0. A full bit is exactly CLKS_PER_BIT cycles. A half bit is CLKS_PER_BIT/2 cycles (integer division).
- IDLE: when rx_s=0, go to START, load the half-bit count, latch eight/pen/ohel for the frame, and clear the bit counter. Config changes during a frame have no effect until the next frame.
- START: on expiry, if rx_s=0, go to DATA and load the full-bit count. If rx_s=1, treat it as a false start and return to IDLE with no flags changed.
- DATA: on each expiry, shift in {rx_s, sr[9:1]} (MSB-in, right shift), increment the bit counter, and reload the full-bit count. The target count is NB = 8 + eight + pen (8..10 samples: data + parity + stop). On the sample that reaches NB, go to LOAD.
- LOAD (one cycle): register the outputs, then go to IDLE. rx_rdy is visible 1 clock after the stop-bit sampling edge.
- Field extraction at LOAD (stop is always sr[9]):
  - eight=1, pen=1: data = sr[7:0], parity = sr[8].
  - eight=1, pen=0: data = sr[8:1].
  - eight=0, pen=1: data = {0, sr[7:1]}, parity = sr[8].
  - eight=0, pen=0: data = {0, sr[8:2]}.
- ferr = ~sr[9]. perr = pen & ((^data ^ parity) != ohel); perr = 0 when pen=0. Both are overwritten at every LOAD.
- ovf: set at LOAD if rx_rdy=1, cleared by rd_clr, otherwise held.
- Simultaneous rd_clr and LOAD: LOAD wins. rx_rdy stays 1 with the new data and ovf is not set.
- rd_clr with no pending character has no effect.
- A frame with ferr=1 still loads and sets rx_rdy. The receiver then waits in IDLE for rx_s=0 again; a line held low restarts reception immediately.
- Reset asserted mid-frame aborts the frame. No partial data or flags survive.

Decomposition:
- Package uart_pkg:
  - state encoding (IDLE, START, DATA, LOAD), 2-bit.
  - default CLKS_PER_BIT.
  - frame-size constants (MAX_BITS=10).
- One natural sub-module: rx_shift_reg_10bit.
  - Ports: clk, reset, sh, sdi, q[9:0].
  - Reset to all 1s; shifts {sdi, q[9:1]} when sh=1.
  - It is the serial-in mirror of the transmit shift register. Field extraction and error logic stay in the parent.

Test Plan:
- CLKS_PER_BIT=16, 8N1 (eight=1, pen=0), send 0xA5 with stop=1 -> rx_data=0xA5, rx_rdy=1 one clock after the stop-sample edge, perr=ferr=ovf=0, busy returns to 0.
- 8 data bits, odd parity (pen=1, ohel=1), send 0x3C with parity=1 -> perr=0. Resend with parity=0 -> perr=1, rx_data=0x3C.
- 7E1 (eight=0, pen=1, ohel=0), send 0x41 with parity=0 -> rx_data=0x41, bit 7=0, perr=0. Resend with stop=0 -> ferr=1, rx_rdy=1.
- 4-cycle low glitch on rx (shorter than half bit) -> stays/returns to IDLE, rx_rdy stays 0, no flags change.
- Two 8N1 frames 0x11 then 0x22 with no rd_clr -> rx_data=0x22, ovf=1. Then pulse rd_clr -> rx_rdy=0, ovf=0. Repeat with rd_clr coincident with the second LOAD -> rx_rdy=1, ovf=0.
- Assert reset=0 during data bit 4 of a frame -> all outputs 0 and busy=0 immediately. After release, a clean frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM encoding, frame sizing
// and the default bit time.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_LOAD  = 2'd3
  } rx_state_t;

  localparam int DEF_CLKS_PER_BIT = 5208;
  localparam int MAX_BITS         = 10;

  // Samples taken after the start bit: data bits + optional parity + stop.
  function automatic logic [3:0] frame_samples(input logic eight, input logic pen);
    return 4'd8 + {3'd0, eight} + {3'd0, pen};
  endfunction

endpackage

// File: rtl/rx_shift_reg_10bit.sv
// Serial-in, right-shifting 10-bit register: the newest bit enters at the MSB,
// so after a full frame the stop bit sits in q[9].
module rx_shift_reg_10bit
  import uart_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                sh,
  input  logic                sdi,
  output logic [MAX_BITS-1:0] q
);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  q <= '1;
    else if (sh) q <= {sdi, q[MAX_BITS-1:1]};
  end

endmodule

// File: rtl/uart_rx_engine.sv
// UART receiver: synchronizes rx, validates the start bit at half a bit time,
// samples each bit at its centre and hands the character to the host side.
module uart_rx_engine
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       eight,
  input  logic       pen,
  input  logic       ohel,
  input  logic       rd_clr,
  output logic [7:0] rx_data,
  output logic       rx_rdy,
  output logic       perr,
  output logic       ferr,
  output logic       ovf,
  output logic       busy
);

  localparam logic [CNT_W-1:0] FULL_LD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LD = CNT_W'(CLKS_PER_BIT / 2 - 1);

  rx_state_t             state;
  logic                  rx_meta, rx_s;
  logic [CNT_W-1:0]      timer;
  logic [3:0]            bit_cnt;
  logic                  eight_q, pen_q, ohel_q;
  logic [MAX_BITS-1:0]   sr;
  logic                  sh;
  logic                  expired;
  logic [7:0]            data_c;
  logic                  par_c;
  logic                  perr_c;

  // Synchronizer resets to the idle line level so no false start follows reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  assign expired = (timer == '0);
  assign sh      = (state == ST_DATA) && expired;

  rx_shift_reg_10bit u_sr (
    .clk   (clk),
    .reset (reset),
    .sh    (sh),
    .sdi   (rx_s),
    .q     (sr)
  );

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    data_c = '0;
    par_c  = 1'b0;
    case ({eight_q, pen_q})
      2'b11: begin data_c = sr[7:0];         par_c = sr[8]; end
      2'b10:       data_c = sr[8:1];
      2'b01: begin data_c = {1'b0, sr[7:1]}; par_c = sr[8]; end
      default:     data_c = {1'b0, sr[8:2]};
    endcase
    perr_c = pen_q & ((^data_c ^ par_c) != ohel_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      timer   <= '0;
      bit_cnt <= '0;
      eight_q <= 1'b0;
      pen_q   <= 1'b0;
      ohel_q  <= 1'b0;
      rx_data <= '0;
      rx_rdy  <= 1'b0;
      perr    <= 1'b0;
      ferr    <= 1'b0;
      ovf     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      // A host read clears the flags; a LOAD later in this block overrides it.
      if (rd_clr) begin
        rx_rdy <= 1'b0;
        ovf    <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            state   <= ST_START;
            timer   <= HALF_LD;
            bit_cnt <= '0;
            eight_q <= eight;
            pen_q   <= pen;
            ohel_q  <= ohel;
            busy    <= 1'b1;
          end
        end
        ST_START: begin
          if (!expired) begin
            timer <= timer - CNT_W'(1);
          end else if (!rx_s) begin
            state <= ST_DATA;
            timer <= FULL_LD;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        ST_DATA: begin
          if (!expired) begin
            timer <= timer - CNT_W'(1);
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
            timer   <= FULL_LD;
            if (bit_cnt + 4'd1 == frame_samples(eight_q, pen_q)) state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          rx_data <= data_c;
          perr    <= perr_c;
          ferr    <= ~sr[MAX_BITS-1];
          rx_rdy  <= 1'b1;
          ovf     <= rd_clr ? 1'b0 : (ovf | rx_rdy);
          state   <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
